// File: rtl/edp_mdu.sv
// edp_mdu: iterative multiply/divide unit for the EBOX data path.
// Operands come from AR (one word) and ARX:MQ (double word); the result is
// returned as hi:lo (AR:MQ). RADIX bits are retired per ITER cycle.
// Optional build macro: EDP_MDU_EARLY_TERM_EN (MUL leaves ITER once the
// remaining multiplier bits are all zero).
//
// Handshake: start is sampled only in IDLE or DONE and is otherwise ignored.
// busy is high in PREP, ITER and FIX. done is a one-cycle pulse, and hi, lo
// and nodiv are valid in that cycle and hold until the next done or reset.
module edp_mdu #(
   parameter int WIDTH = 36,
   parameter int RADIX = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] ar,
   input  logic [WIDTH-1:0] arx,
   input  logic [WIDTH-1:0] mq,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             nodiv
);

   localparam int N  = WIDTH / RADIX;
   localparam int CW = $clog2(N + 1);
   localparam int MW = WIDTH + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREP,
      S_ITER,
      S_FIX,
      S_DONE
   } state_t;

   state_t state, state_nx;

   // Request captured at the start edge
   logic [1:0]       op_r;
   logic [WIDTH-1:0] ar_r, arx_r, mq_r;

   // Working registers: w_hi:w_lo is the product accumulator (MUL) or the
   // remainder:quotient shift pair (DIV); dvs holds |multiplicand| or |divisor|.
   logic [WIDTH-1:0] w_hi, w_lo, mpl;
   logic [MW-1:0]    dvs;
   logic [CW-1:0]    cnt;
   logic             sgn_p, sgn_r;

   // PREP signals
   logic               is_div, is_sgn, s_ar, s_arx, s_mq, q_neg, ovf;
   logic [WIDTH-1:0]   ar_mag, mq_mag;
   logic [2*WIDTH-1:0] dd_mag;
   logic [2*WIDTH:0]   lim;

   // ITER / FIX signals
   logic [WIDTH+RADIX-1:0] addend, sum;
   logic [WIDTH-1:0]       mul_hi, mul_lo, mpl_nx;
   logic [WIDTH-1:0]       div_r, div_q, step_hi, step_lo;
   logic [MW-1:0]          trial;
   logic                   q_bit, early, iter_last;
   logic [2*WIDTH-1:0]     fix_p;
   logic [WIDTH-1:0]       fix_hi, fix_lo;

   assign busy = (state == S_PREP) || (state == S_ITER) || (state == S_FIX);
   assign done = (state == S_DONE);

   // Operand magnitudes, result signs and the divide-overflow decision
   always_comb begin
      is_div = op_r[1];
      is_sgn = op_r[0];
      s_ar   = is_sgn & ar_r[WIDTH-1];
      s_arx  = is_sgn & arx_r[WIDTH-1];
      s_mq   = is_sgn & mq_r[WIDTH-1];
      q_neg  = s_arx ^ s_ar;
      // A most-negative word negates to itself, which read unsigned is the
      // exact magnitude 2^(WIDTH-1).
      ar_mag = s_ar ? -ar_r : ar_r;
      mq_mag = s_mq ? -mq_r : mq_r;
      dd_mag = s_arx ? -{arx_r, mq_r} : {arx_r, mq_r};
      // Smallest dividend magnitude whose quotient leaves the signed range:
      // |d|*2^(WIDTH-1) for a positive quotient, |d|*(2^(WIDTH-1)+1) for a
      // negative one (so -2^(WIDTH-1) itself stays legal).
      lim = {2'b00, ar_mag, {(WIDTH-1){1'b0}}} +
            (q_neg ? {{(WIDTH+1){1'b0}}, ar_mag} : {(2*WIDTH+1){1'b0}});
      ovf = is_div & ((dd_mag[2*WIDTH-1:WIDTH] >= ar_mag) |
                      (is_sgn & ({1'b0, dd_mag} >= lim)));
   end

   // One ITER step for both operations, plus the FIX sign correction
   always_comb begin
      // MUL: add digit*|multiplicand| to the high word, shift right by RADIX
      addend = '0;
      for (int j = 0; j < RADIX; j++) begin
         if (mpl[j]) addend = addend + ((WIDTH+RADIX)'(dvs[WIDTH-1:0]) << j);
      end
      sum    = {{RADIX{1'b0}}, w_hi} + addend;
      mul_hi = sum[RADIX +: WIDTH];
      mul_lo = {sum[RADIX-1:0], w_lo[WIDTH-1:RADIX]};
      mpl_nx = mpl >> RADIX;
      early  = 1'b0;
`ifdef EDP_MDU_EARLY_TERM_EN
      // Remaining digits are zero: apply all their right shifts now
      if (!op_r[1] && (mpl_nx == '0) && (cnt != LAST)) begin
         early = 1'b1;
         {mul_hi, mul_lo} = {mul_hi, mul_lo} >> (RADIX * (N - 1 - int'(cnt)));
      end
`endif
      // DIV: RADIX restoring steps on remainder:quotient
      div_r = w_hi;
      div_q = w_lo;
      for (int j = 0; j < RADIX; j++) begin
         trial = {div_r, div_q[WIDTH-1]};
         q_bit = (trial >= dvs);
         if (q_bit) trial = trial - dvs;
         div_r = trial[WIDTH-1:0];
         div_q = {div_q[WIDTH-2:0], q_bit};
      end
      step_hi   = op_r[1] ? div_r : mul_hi;
      step_lo   = op_r[1] ? div_q : mul_lo;
      iter_last = (cnt == LAST) | early;
      // FIX: negating zero yields zero, so a zero result is never negated
      fix_p = {w_hi, w_lo};
      if (sgn_p) fix_p = -fix_p;
      fix_hi = fix_p[2*WIDTH-1:WIDTH];
      fix_lo = fix_p[WIDTH-1:0];
      if (op_r[1]) begin
         fix_lo = sgn_p ? -w_lo : w_lo;
         fix_hi = sgn_r ? -w_hi : w_hi;
      end
   end

   // Next-state decode
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_PREP;
         S_PREP:  state_nx = ovf ? S_DONE : S_ITER;
         S_ITER:  if (iter_last) state_nx = S_FIX;
         S_FIX:   state_nx = S_DONE;
         S_DONE:  state_nx = start ? S_PREP : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   // Operand capture, iteration datapath and result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         op_r  <= '0;
         ar_r  <= '0;
         arx_r <= '0;
         mq_r  <= '0;
         w_hi  <= '0;
         w_lo  <= '0;
         mpl   <= '0;
         dvs   <= '0;
         cnt   <= '0;
         sgn_p <= 1'b0;
         sgn_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         nodiv <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  op_r  <= op;
                  ar_r  <= ar;
                  arx_r <= arx;
                  mq_r  <= mq;
               end
            end
            S_PREP: begin
               cnt   <= '0;
               sgn_p <= is_div ? q_neg : (s_ar ^ s_mq);
               sgn_r <= s_arx;
               dvs   <= {1'b0, ar_mag};
               if (is_div) begin
                  w_hi <= dd_mag[2*WIDTH-1:WIDTH];
                  w_lo <= dd_mag[WIDTH-1:0];
                  mpl  <= '0;
               end else begin
                  w_hi <= '0;
                  w_lo <= '0;
                  mpl  <= mq_mag;
               end
               if (ovf) begin
                  hi    <= arx_r;
                  lo    <= mq_r;
                  nodiv <= 1'b1;
               end
            end
            S_ITER: begin
               cnt  <= cnt + 1'b1;
               w_hi <= step_hi;
               w_lo <= step_lo;
               mpl  <= mpl_nx;
            end
            S_FIX: begin
               hi    <= fix_hi;
               lo    <= fix_lo;
               nodiv <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/edp_mdu.md
Name: edp_mdu

Overview:
Parametrised iterative multiply/divide unit for the EBOX data path. It is the multi-cycle successor to the single-step AR/ARX/MQ shift-and-add microcode loops. Operands are loaded from AR (one-word operand) and ARX:MQ (double-length operand). The unit retires RADIX bits per clock and returns a double-length result as hi:lo, mapping to AR:MQ. It also flags the KL10 "no divide" condition.

Parameters:
WIDTH, 36, word width in bits; must be a multiple of RADIX.
RADIX, 1, bits retired per ITER cycle; legal values are 1 or 2.
N (localparam), WIDTH/RADIX, number of ITER cycles.

Ports:
clk  in  1  EBOX data-path clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
start  in  1  request; sampled only in IDLE or DONE.
op  in  2  00 unsigned MUL, 01 signed MUL, 10 unsigned DIV, 11 signed DIV.
ar  in  WIDTH  MUL multiplicand; DIV divisor.
arx  in  WIDTH  MUL ignored; DIV dividend high word.
mq  in  WIDTH  MUL multiplier; DIV dividend low word.
busy  out  1  high in PREP, ITER and FIX.
done  out  1  one-cycle pulse; hi, lo and nodiv are valid in that cycle.
hi  out  WIDTH  product high word, or remainder.
lo  out  WIDTH  product low word, or quotient.
nodiv  out  1  divide overflow or divide by zero; valid with done.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, nodiv=0, hi=0, lo=0; iteration counter=0. Reset in any state aborts the operation, and no done pulse is produced.
- Operands and op are captured at the start edge. Input changes after that have no effect.
- States:
  - IDLE: start -> PREP.
  - PREP, 1 cycle: take magnitudes for signed ops; record result sign(s); run the DIV overflow check.
  - ITER, N cycles.
  - FIX, 1 cycle: apply sign correction.
  - DONE, 1 cycle: done=1. start -> PREP; otherwise -> IDLE.
- Latency:
  - start high in cycle 0 gives done in cycle N+3.
  - Back-to-back: start high during DONE gives the next done N+3 cycles later.
- start while busy is ignored; it is neither queued nor an error.
- MUL:
  - Shift-and-add over a 2*WIDTH accumulator, RADIX multiplier bits per cycle. RADIX=2 adds 0, 1x, 2x or 3x.
  - Unsigned result: full 2*WIDTH product.
  - Signed result: two's-complement 2*WIDTH product; negated in FIX when operand signs differ.
  - MUL never sets nodiv.
- DIV:
  - Restoring division of the 2*WIDTH magnitude by the WIDTH magnitude; RADIX quotient bits per cycle.
  - Quotient sign = sign(arx) XOR sign(ar). Remainder sign = dividend sign. A zero result is never negated.
- DIV overflow, decided in PREP: |arx:mq| high word >= |ar|, which includes ar=0. Signed DIV also overflows if the magnitude quotient exceeds the signed range.
  - Exception to the above: a quotient of exactly -2^(WIDTH-1) is legal.
  - On overflow, skip ITER and FIX and go PREP -> DONE, so done comes in cycle 2.
  - With overflow: nodiv=1, hi=arx, lo=mq (operands returned unchanged).
- hi, lo and nodiv hold their values after done until the next done or reset.
- Signed ops use the most-negative operand magnitude 2^(WIDTH-1) exactly; the internal magnitude path is WIDTH+1 bits.

Optional Feature:
Macro EDP_MDU_EARLY_TERM_EN.
- When defined, MUL leaves ITER early if every remaining unretired multiplier bit is zero. The remaining shift is applied in a single cycle, then the unit goes to FIX. done then arrives in cycle k+3, where k is the number of ITER cycles actually taken, with 1 <= k <= N. Results are identical to the full-length case.
- DIV timing is unchanged.
- When undefined, MUL always takes N ITER cycles.

Test Plan:
1. WIDTH=36, RADIX=1, op=00, ar=3, mq=5 -> done in cycle 39; hi=0, lo=15, nodiv=0; busy high in cycles 1-38.
2. op=01, ar=-1, mq=1 -> hi=lo=36'o777777777777. Also op=01, ar=mq=-2^35 -> hi=36'o200000000000, lo=0.
3. op=10, arx=0, mq=100, ar=7 -> lo=14, hi=2. Also op=11 with arx:mq = -100 (double length), ar=7 -> lo=-14, hi=-2.
4. op=10, ar=0, arx=5, mq=9 -> done in cycle 2; nodiv=1, hi=5, lo=9. Also arx=7, ar=7 -> nodiv=1.
5. Reset asserted in ITER cycle 10 -> IDLE next cycle, busy=0, no done, hi=lo=0. start re-asserted one cycle later -> normal completion. start pulsed mid-op is ignored. start held during DONE gives back-to-back done 39 cycles apart.
6. RADIX=2 repeat of scenarios 1-3 -> done in cycle 21. With EDP_MDU_EARLY_TERM_EN, op=00, mq=1, ar=12345 -> done in cycle 4, lo=12345.
